// File: rtl/regbus_xbar.sv
// rtl/regbus_xbar.sv - single-outstanding register-bus fabric with window decode, timeout and error stats
module regbus_xbar #(
  parameter int          NSLAVE  = 4,
  parameter int          WINBITS = 12,
  parameter logic [31:0] BASE    = 32'h4000_0000,
  parameter int          TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  input  logic [3:0]             m_wstrb,
  input  logic                   m_wr,
  input  logic                   m_req,
  output logic                   m_ack,
  output logic                   m_err,
  output logic [31:0]            m_rdata,
  output logic [WINBITS-1:0]     s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  output logic                   s_wr,
  output logic [NSLAVE-1:0]      s_req,
  input  logic [NSLAVE-1:0]      s_ack,
  input  logic [NSLAVE-1:0]      s_err,
  input  logic [32*NSLAVE-1:0]   s_rdata,
  input  logic                   err_clr,
  output logic [15:0]            err_count,
  output logic [31:0]            err_addr,
  output logic                   ovr
);

  localparam int              IDXW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int              UPW  = 32 - WINBITS - IDXW;
  localparam int              TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);
  localparam logic [IDXW:0]   NS_W = (IDXW + 1)'(NSLAVE);

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                wr_q, wr_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [NSLAVE-1:0]   sreq_q, sreq_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         eaddr_q, eaddr_d;
  logic                ovr_q, ovr_d;

  logic [IDXW-1:0]     idx_in;
  logic                hit_in;
  logic                ack_sel, err_sel;
  logic [31:0]         rdata_sel;

  assign idx_in    = m_addr[WINBITS +: IDXW];
  assign hit_in    = (m_addr[31 -: UPW] == BASE[31 -: UPW]) && ({1'b0, idx_in} < NS_W);
  assign ack_sel   = s_ack[idx_q];
  assign err_sel   = s_err[idx_q];
  assign rdata_sel = s_rdata[{idx_q, 5'b0} +: 32];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    sreq_d  = '0;
    timer_d = timer_q;
    pend_d  = pend_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    ovr_d   = ovr_q | (m_req && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          wr_d    = m_wr;
          idx_d   = idx_in;
          hit_d   = hit_in;
          sreq_d  = hit_in ? (NSLAVE'(1) << idx_in) : '0;
          pend_d  = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (hit_q) begin
          timer_d = '0;
          // A combinational slave may ack alongside s_req; hold it so WAIT completes next cycle.
          if (ack_sel) begin
            rdata_d = rdata_sel;
            err_d   = err_sel;
            pend_d  = 1'b1;
          end
          state_d = ST_WAIT;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (pend_q) begin
          state_d = ST_RESP;
        end else if (ack_sel) begin
          rdata_d = rdata_sel;
          err_d   = err_sel;
          state_d = ST_RESP;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_RESP) && err_q) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      eaddr_d = addr_q;
    end
    if (err_clr) begin
      cnt_d   = '0;
      eaddr_d = '0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      sreq_q  <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      sreq_q  <= sreq_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_ack     = (state_q == ST_RESP);
  assign m_err     = m_ack & err_q;
  assign m_rdata   = rdata_q;
  assign s_addr    = addr_q[WINBITS-1:0];
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign s_wr      = wr_q;
  assign s_req     = sreq_q;
  assign err_count = cnt_q;
  assign err_addr  = eaddr_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_regbus_xbar.sv
// tb/tb_regbus_xbar.sv - directed bench for regbus_xbar (NSLAVE=4, WINBITS=12, TIMEOUT=8)
module tb_regbus_xbar;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_wr, m_req;
  logic         m_ack, m_err;
  logic [31:0]  m_rdata;
  logic [11:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wr;
  logic [3:0]   s_req, s_ack, s_err;
  logic [127:0] s_rdata;
  logic         err_clr;
  logic [15:0]  err_count;
  logic [31:0]  err_addr;
  logic         ovr;

  int total = 0;
  int bad   = 0;
  logic seen;

  regbus_xbar #(.NSLAVE(4), .WINBITS(12), .BASE(32'h4000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wr(m_wr), .m_req(m_req),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wr(s_wr),
    .s_req(s_req), .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
    .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr), .ovr(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives m_req during cycle 0 and returns positioned in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input logic w);
    m_addr  = a;
    m_wdata = d;
    m_wstrb = st;
    m_wr    = w;
    m_req   = 1'b1;
    step();
    m_req   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_wr = 1'b0; m_req = 1'b0;
    s_ack = '0; s_err = '0; err_clr = 1'b0;
    s_rdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    step(); step();
    rst = 1'b0;
    chk("rst_m_ack", {31'd0, m_ack}, 32'd0);
    chk("rst_s_req", {28'd0, s_req}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_s_addr", {20'd0, s_addr}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);

    // read hit on slave 2, ack two cycles after s_req
    issue(32'h4000_2010, 32'h0, 4'h0, 1'b0);
    chk("rd_s_req", {28'd0, s_req}, 32'h4);
    chk("rd_s_addr", {20'd0, s_addr}, 32'h010);
    chk("rd_s_wr", {31'd0, s_wr}, 32'd0);
    step();
    chk("rd_noack_c2", {31'd0, m_ack}, 32'd0);
    chk("rd_s_req_c2", {28'd0, s_req}, 32'd0);
    step();
    s_ack[2] = 1'b1; s_rdata[64 +: 32] = 32'h1234_5678;
    chk("rd_noack_c3", {31'd0, m_ack}, 32'd0);
    step();
    s_ack = '0;
    chk("rd_ack_c4", {31'd0, m_ack}, 32'd1);
    chk("rd_rdata", m_rdata, 32'h1234_5678);
    chk("rd_err", {31'd0, m_err}, 32'd0);
    step();
    chk("rd_ack_drop", {31'd0, m_ack}, 32'd0);

    // write to slave 0, combinational ack with error in cycle 1
    issue(32'h4000_0004, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    chk("wr_s_req", {28'd0, s_req}, 32'h1);
    chk("wr_s_wstrb", {28'd0, s_wstrb}, 32'h3);
    chk("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_s_wr", {31'd0, s_wr}, 32'd1);
    s_ack[0] = 1'b1; s_err[0] = 1'b1;
    step();
    s_ack = '0; s_err = '0;
    chk("wr_noack_c2", {31'd0, m_ack}, 32'd0);
    step();
    chk("wr_ack_c3", {31'd0, m_ack}, 32'd1);
    chk("wr_err", {31'd0, m_err}, 32'd1);
    step();
    chk("wr_err_count", {16'd0, err_count}, 32'd1);
    chk("wr_err_addr", err_addr, 32'h4000_0004);

    // unmapped addresses
    issue(32'h4000_4000, 32'h0, 4'h0, 1'b0);
    chk("um1_s_req", {28'd0, s_req}, 32'd0);
    step();
    chk("um1_ack_c2", {31'd0, m_ack}, 32'd1);
    chk("um1_err", {31'd0, m_err}, 32'd1);
    chk("um1_rdata", m_rdata, 32'd0);
    step();
    issue(32'h5000_0000, 32'h0, 4'h0, 1'b0);
    chk("um2_s_req", {28'd0, s_req}, 32'd0);
    step();
    chk("um2_ack_c2", {31'd0, m_ack}, 32'd1);
    chk("um2_err", {31'd0, m_err}, 32'd1);
    step();
    chk("um_err_count", {16'd0, err_count}, 32'd3);
    chk("um_err_addr", err_addr, 32'h5000_0000);

    // timeout on slave 1, then a late ack
    issue(32'h4000_1000, 32'h0, 4'h0, 1'b0);
    chk("to_s_req", {28'd0, s_req}, 32'h2);
    seen = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step();
      seen = seen | m_ack;
    end
    chk("to_no_early_ack", {31'd0, seen}, 32'd0);
    step();
    chk("to_ack_c11", {31'd0, m_ack}, 32'd1);
    chk("to_err", {31'd0, m_err}, 32'd1);
    chk("to_rdata", m_rdata, 32'd0);
    for (int c = 12; c <= 15; c++) step();
    s_ack[1] = 1'b1;
    seen = 1'b0;
    for (int c = 16; c <= 19; c++) begin
      step();
      s_ack = '0;
      seen = seen | m_ack;
    end
    chk("to_late_ack_ignored", {31'd0, seen}, 32'd0);
    chk("to_err_count", {16'd0, err_count}, 32'd4);

    // ack in the same cycle the timer reaches TIMEOUT
    issue(32'h4000_1000, 32'h0, 4'h0, 1'b0);
    seen = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step();
      seen = seen | m_ack;
    end
    chk("tie_no_early_ack", {31'd0, seen}, 32'd0);
    s_ack[1] = 1'b1; s_rdata[32 +: 32] = 32'hCAFE_0001;
    step();
    s_ack = '0;
    chk("tie_ack_c11", {31'd0, m_ack}, 32'd1);
    chk("tie_err", {31'd0, m_err}, 32'd0);
    chk("tie_rdata", m_rdata, 32'hCAFE_0001);
    step();
    chk("tie_err_count", {16'd0, err_count}, 32'd4);

    // overrun and stray ack during WAIT
    issue(32'h4000_0000, 32'h0, 4'h0, 1'b0);
    step();
    m_addr = 32'h4000_3000; m_wr = 1'b1; m_req = 1'b1; s_ack[3] = 1'b1;
    step();
    m_req = 1'b0; s_ack = '0;
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    chk("ovr_no_ack", {31'd0, m_ack}, 32'd0);
    chk("ovr_no_s_req", {28'd0, s_req}, 32'd0);
    chk("ovr_s_addr_kept", {20'd0, s_addr}, 32'h000);
    s_ack[0] = 1'b1; s_rdata[0 +: 32] = 32'h0BAD_F00D;
    step();
    s_ack = '0;
    chk("ovr_ack", {31'd0, m_ack}, 32'd1);
    chk("ovr_err", {31'd0, m_err}, 32'd0);
    chk("ovr_rdata", m_rdata, 32'h0BAD_F00D);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ovr", {31'd0, ovr}, 32'd0);
    chk("clr_err_count", {16'd0, err_count}, 32'd0);
    chk("clr_err_addr", err_addr, 32'd0);

    // err_clr coincides with an error completion
    issue(32'h5000_0000, 32'h0, 4'h0, 1'b0);
    step();
    chk("clrp_ack", {31'd0, m_ack}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clrp_err_count", {16'd0, err_count}, 32'd0);

    // reset in the middle of WAIT
    issue(32'h5000_0000, 32'h0, 4'h0, 1'b0);
    step(); step();
    chk("pre_rst_err_count", {16'd0, err_count}, 32'd1);
    issue(32'h4000_2ABC, 32'h1111_2222, 4'hF, 1'b1);
    step();
    rst = 1'b1; m_req = 1'b1;
    step();
    rst = 1'b0; m_req = 1'b0;
    chk("mrst_m_ack", {31'd0, m_ack}, 32'd0);
    chk("mrst_s_req", {28'd0, s_req}, 32'd0);
    chk("mrst_s_addr", {20'd0, s_addr}, 32'd0);
    chk("mrst_s_wdata", s_wdata, 32'd0);
    chk("mrst_s_wr", {31'd0, s_wr}, 32'd0);
    chk("mrst_err_count", {16'd0, err_count}, 32'd0);
    chk("mrst_ovr", {31'd0, ovr}, 32'd0);
    s_ack[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      s_ack = '0;
      seen = seen | m_ack;
    end
    chk("mrst_stray_ignored", {31'd0, seen}, 32'd0);
    chk("mrst_rdata", m_rdata, 32'd0);
    issue(32'h4000_3008, 32'h0, 4'h0, 1'b0);
    chk("post_s_req", {28'd0, s_req}, 32'h8);
    chk("post_s_addr", {20'd0, s_addr}, 32'h008);
    step();
    s_ack[3] = 1'b1; s_rdata[96 +: 32] = 32'h600D_CAFE;
    step();
    s_ack = '0;
    chk("post_ack_c3", {31'd0, m_ack}, 32'd1);
    chk("post_rdata", m_rdata, 32'h600D_CAFE);
    chk("post_err", {31'd0, m_err}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
